// File: rtl/vga_rx_monitor.sv
// Recovers pixel coordinates from VGA syncs, measures line/frame timing, keeps a lock state and probes one pixel.
// Latency: 3 clk from pin sample to px_valid (2-FF sync + output register); probe_hit follows px_valid by 1 clk.
// Backpressure: none; this is a pure observer and every output is a registered pulse or level.
module vga_rx_monitor #(
    parameter int CLK_PER_PIX = 4,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACT       = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACT       = 480,
    parameter int V_TOTAL     = 525
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hSync,
    input  logic        vSync,
    input  logic [11:0] rgb_in,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    input  logic        clr_err,
    output logic        px_valid,
    output logic [9:0]  px_x,
    output logic [9:0]  px_y,
    output logic [11:0] px_rgb,
    output logic [11:0] probe_rgb,
    output logic        probe_hit,
    output logic        frame_done,
    output logic [11:0] line_clks,
    output logic [9:0]  frame_lines,
    output logic        locked,
    output logic        err_h,
    output logic        err_v
);

    localparam int PW = (CLK_PER_PIX > 2) ? $clog2(CLK_PER_PIX) : 1;
    localparam logic [PW-1:0] PH_LAST   = PW'(CLK_PER_PIX - 1);
    localparam logic [PW-1:0] PH_MID    = PW'(CLK_PER_PIX / 2);
    localparam logic [12:0]   LINE_LEN  = 13'(H_TOTAL * CLK_PER_PIX);
    localparam logic [10:0]   FRAME_LEN = 11'(V_TOTAL);
    localparam logic [9:0]    H_FIRST   = 10'(H_SYNC + H_BP);
    localparam logic [10:0]   H_END     = 11'(H_SYNC + H_BP + H_ACT);
    localparam logic [9:0]    V_FIRST   = 10'(V_SYNC + V_BP);
    localparam logic [10:0]   V_END     = 11'(V_SYNC + V_BP + V_ACT);

    typedef enum logic [1:0] {
        S_SEEK   = 2'd0,
        S_ALIGN  = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic          hs_s1, hs_s2, hs_d;
    logic          vs_s1, vs_s2, vs_d;
    logic [11:0]   rgb_d1, rgb_d2;
    logic [11:0]   clk_cnt;
    logic [PW-1:0] pix_phase;
    logic [9:0]    h_pix;
    logic [9:0]    v_line;
    logic          vs_pend;
    logic          frame_bad;

    logic          hs_fall, vs_fall, frame_evt, measure;
    logic          h_err_evt, v_err_evt, err_evt;
    logic [12:0]   line_len;
    logic [10:0]   frame_len;
    logic          px_hit, probe_match;

    assign hs_fall   = hs_d & ~hs_s2;
    assign vs_fall   = vs_d & ~vs_s2;
    // vSync may fall on the very cycle of the hSync edge that closes the frame
    assign frame_evt = hs_fall & (vs_pend | vs_fall);
    assign line_len  = {1'b0, clk_cnt} + 13'd1;
    assign frame_len = {1'b0, v_line} + 11'd1;

    // SEEK only runs until the first frame event, so it also masks the first post-reset line
    assign measure   = hs_fall & (state != S_SEEK);
    assign h_err_evt = measure & (line_len != LINE_LEN);
    assign v_err_evt = frame_evt & (state != S_SEEK) & (frame_len != FRAME_LEN);
    assign err_evt   = h_err_evt | v_err_evt;

    assign px_hit = (state != S_SEEK) && (pix_phase == PH_MID)
                 && (h_pix >= H_FIRST) && ({1'b0, h_pix} < H_END)
                 && (v_line >= V_FIRST) && ({1'b0, v_line} < V_END);
    assign probe_match = px_valid && (px_x == probe_x) && (px_y == probe_y);

    assign locked = (state == S_LOCKED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hs_s1  <= 1'b0;
            hs_s2  <= 1'b0;
            hs_d   <= 1'b0;
            vs_s1  <= 1'b0;
            vs_s2  <= 1'b0;
            vs_d   <= 1'b0;
            rgb_d1 <= '0;
            rgb_d2 <= '0;
        end else begin
            hs_s1  <= hSync;
            hs_s2  <= hs_s1;
            hs_d   <= hs_s2;
            vs_s1  <= vSync;
            vs_s2  <= vs_s1;
            vs_d   <= vs_s2;
            rgb_d1 <= rgb_in;
            rgb_d2 <= rgb_d1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_cnt   <= '0;
            pix_phase <= '0;
            h_pix     <= '0;
            v_line    <= '0;
            vs_pend   <= 1'b0;
        end else begin
            if (hs_fall) begin
                clk_cnt   <= '0;
                pix_phase <= '0;
                h_pix     <= '0;
            end else begin
                if (clk_cnt != 12'hfff) clk_cnt <= clk_cnt + 12'd1;
                if (pix_phase == PH_LAST) begin
                    pix_phase <= '0;
                    if (h_pix != 10'h3ff) h_pix <= h_pix + 10'd1;
                end else begin
                    pix_phase <= pix_phase + PW'(1);
                end
            end
            if (frame_evt) begin
                vs_pend <= 1'b0;
                v_line  <= '0;
            end else begin
                if (vs_fall) vs_pend <= 1'b1;
                if (hs_fall && v_line != 10'h3ff) v_line <= v_line + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_clks   <= '0;
            frame_lines <= '0;
            frame_done  <= 1'b0;
            err_h       <= 1'b0;
            err_v       <= 1'b0;
            frame_bad   <= 1'b0;
            state       <= S_SEEK;
        end else begin
            frame_done <= frame_evt;
            if (measure)   line_clks   <= line_len[11:0];
            if (frame_evt) frame_lines <= frame_len[9:0];
            if (h_err_evt)    err_h <= 1'b1;
            else if (clr_err) err_h <= 1'b0;
            if (v_err_evt)    err_v <= 1'b1;
            else if (clr_err) err_v <= 1'b0;
            if (frame_evt)    frame_bad <= 1'b0;
            else if (err_evt) frame_bad <= 1'b1;
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_SEEK:   if (frame_evt) state_nxt = S_ALIGN;
            S_ALIGN:  if (frame_evt && !frame_bad && !err_evt) state_nxt = S_LOCKED;
            S_LOCKED: if (err_evt) state_nxt = S_ALIGN;
            default:  state_nxt = S_SEEK;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            px_valid  <= 1'b0;
            px_x      <= '0;
            px_y      <= '0;
            px_rgb    <= '0;
            probe_rgb <= '0;
            probe_hit <= 1'b0;
        end else begin
            px_valid  <= px_hit;
            probe_hit <= probe_match;
            if (px_hit) begin
                px_x   <= h_pix - H_FIRST;
                px_y   <= v_line - V_FIRST;
                px_rgb <= rgb_d2;
            end
            if (probe_match) probe_rgb <= px_rgb;
        end
    end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Scoreboarded bench for vga_rx_monitor on a scaled-down raster: random pixel colours,
// timing faults, early vSync, clr_err and a mid-frame reset.
module tb_vga_rx_monitor;

    localparam int C    = 4;
    localparam int HS   = 2;
    localparam int HBP  = 2;
    localparam int HACT = 10;
    localparam int HTOT = 16;
    localparam int VS   = 1;
    localparam int VBP  = 2;
    localparam int VACT = 5;
    localparam int VTOT = 10;
    localparam int HOFF = HS + HBP;
    localparam int VOFF = VS + VBP;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hSync, vSync, clr_err;
    logic [11:0] rgb_in;
    logic [9:0]  probe_x, probe_y;
    logic        px_valid, probe_hit, frame_done, locked, err_h, err_v;
    logic [9:0]  px_x, px_y, frame_lines;
    logic [11:0] px_rgb, probe_rgb, line_clks;

    always #5 clk = ~clk;

    vga_rx_monitor #(
        .CLK_PER_PIX(C), .H_SYNC(HS), .H_BP(HBP), .H_ACT(HACT), .H_TOTAL(HTOT),
        .V_SYNC(VS), .V_BP(VBP), .V_ACT(VACT), .V_TOTAL(VTOT)
    ) dut (
        .clk(clk), .rst(rst), .hSync(hSync), .vSync(vSync), .rgb_in(rgb_in),
        .probe_x(probe_x), .probe_y(probe_y), .clr_err(clr_err),
        .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_rgb(px_rgb),
        .probe_rgb(probe_rgb), .probe_hit(probe_hit), .frame_done(frame_done),
        .line_clks(line_clks), .frame_lines(frame_lines), .locked(locked),
        .err_h(err_h), .err_v(err_v)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          fd_cnt      = 0;
    bit          tracking    = 1'b0;
    logic [31:0] px_q[$];
    logic [11:0] probe_q[$];

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One frame of raster; the model pushes every active pixel it expects the DUT to report.
    task automatic run_frame(input int nl, input int short_l, input bit early,
                             input int rst_l, input int clr_l, input int chk_l,
                             input int e_lock, input int e_eh, input int e_ev,
                             input int e_lc, input int e_fl);
        int npix, x, y;
        logic [11:0] rgbv;
        tracking = 1'b1;
        for (int l = 0; l < nl; l++) begin
            npix = (l == short_l) ? HTOT - 1 : HTOT;
            for (int p = 0; p < npix; p++) begin
                rgbv = 12'($urandom);
                x = p - HOFF;
                y = l - VOFF;
                for (int c = 0; c < C; c++) begin
                    @(posedge clk);
                    #1;
                    if (l == chk_l && p == 8 && c == 0) begin
                        chk("locked", int'(locked), e_lock);
                        chk("err_h", int'(err_h), e_eh);
                        chk("err_v", int'(err_v), e_ev);
                        chk("line_clks", int'(line_clks), e_lc);
                        if (e_fl >= 0) chk("frame_lines", int'(frame_lines), e_fl);
                    end
                    if (l == rst_l && p == 0 && c == 0) tracking = 1'b0;
                    rst     = !(l == rst_l && p == 0 && c < 3);
                    clr_err = (l == clr_l && p == 4 && c == 0);
                    hSync   = (p >= HS);
                    vSync   = !((l < VS) || (early && l == nl - 1 && p >= npix - 3));
                    rgb_in  = rgbv;
                    if (c == 0 && tracking && x >= 0 && x < HACT && y >= 0 && y < VACT) begin
                        px_q.push_back({10'(x), 10'(y), rgbv});
                        if (10'(x) == probe_x && 10'(y) == probe_y) probe_q.push_back(rgbv);
                    end
                end
            end
        end
    endtask

    logic [31:0] exp_px;
    logic [11:0] exp_probe;

    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            if ({px_valid, px_x, px_y, px_rgb, probe_rgb, probe_hit, frame_done,
                 line_clks, frame_lines, locked, err_h, err_v} != '0) begin
                miscompares++;
                $display("FAIL reset_outputs: got nonzero outputs, expected all 0");
            end
        end else begin
            if (px_valid) begin
                vectors++;
                if (px_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL px_unexpected: got x=%0d y=%0d rgb=%h, expected none",
                             px_x, px_y, px_rgb);
                end else begin
                    exp_px = px_q.pop_front();
                    if ({px_x, px_y, px_rgb} != exp_px) begin
                        miscompares++;
                        $display("FAIL px: got x=%0d y=%0d rgb=%h expected x=%0d y=%0d rgb=%h",
                                 px_x, px_y, px_rgb, exp_px[31:22], exp_px[21:12], exp_px[11:0]);
                    end
                end
            end
            if (probe_hit) begin
                vectors++;
                if (probe_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL probe_unexpected: got hit rgb=%h, expected none", probe_rgb);
                end else begin
                    exp_probe = probe_q.pop_front();
                    if (probe_rgb != exp_probe) begin
                        miscompares++;
                        $display("FAIL probe_rgb: got %h expected %h", probe_rgb, exp_probe);
                    end
                end
            end
            if (frame_done) fd_cnt++;
        end
    end

    initial begin
        hSync   = 1'b1;
        vSync   = 1'b1;
        rgb_in  = '0;
        clr_err = 1'b0;
        probe_x = 10'(HACT - 1);
        probe_y = 10'(VACT - 1);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        repeat (8) @(posedge clk);

        // nl, short, early, rst_l, clr_l, chk_l, lock, err_h, err_v, line_clks, frame_lines
        run_frame(VTOT, -1, 0, -1, -1, 1, 0, 0, 0, HTOT*C, -1);
        run_frame(VTOT, -1, 0, -1, -1, 1, 1, 0, 0, HTOT*C, VTOT);
        run_frame(VTOT,  3, 0, -1, -1, 4, 0, 1, 0, (HTOT-1)*C, VTOT);
        run_frame(VTOT, -1, 0, -1,  1, 2, 0, 0, 0, HTOT*C, VTOT);
        run_frame(VTOT, -1, 0, -1, -1, 1, 1, 0, 0, HTOT*C, VTOT);
        probe_x = 10'(HACT);
        probe_y = 10'd0;
        run_frame(VTOT-1, -1, 0, -1, -1, 1, 1, 0, 0, HTOT*C, VTOT);
        run_frame(VTOT, -1, 1, -1, -1, 1, 0, 0, 1, HTOT*C, VTOT-1);
        probe_x = 10'($urandom_range(HACT - 1));
        probe_y = 10'($urandom_range(VACT - 1));
        run_frame(VTOT, -1, 0, -1,  1, 2, 1, 0, 0, HTOT*C, VTOT);
        run_frame(VTOT, -1, 0,  5, -1, 7, 0, 0, 0, 0, 0);
        run_frame(VTOT, -1, 0, -1, -1, 1, 0, 0, 0, HTOT*C, -1);
        run_frame(VTOT, -1, 0, -1, -1, 1, 1, 0, 0, HTOT*C, VTOT);

        repeat (20) @(posedge clk);
        #1;
        chk("px_queue_drained", px_q.size(), 0);
        chk("probe_queue_drained", probe_q.size(), 0);
        chk("frame_done_count", fd_cnt, 11);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
